pack_fifo_flush_p: RTL and testbench

//   Parametrised packing FIFO, successor to the fixed 4b->32b flush FIFO. It accumulates IN_W-bit

---
 rtl/pack_fifo_pkg.sv | 15 +
 rtl/pack_fifo_mem.sv | 28 ++
 rtl/pack_fifo_flush_p.sv | 174 +++++++++++++++++
 tb/tb_pack_fifo_flush_p.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pack_fifo_pkg.sv
// Shared types and helpers for the packing FIFO: FSM state encoding and lane-index width.
package pack_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PAD   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // A one-lane row still needs a 1-bit lane pointer.
    function automatic int lane_w(input int pack);
        return (pack > 1) ? $clog2(pack) : 1;
    endfunction

endpackage

// File: rtl/pack_fifo_mem.sv
// Row storage: DEPTH x W, one synchronous write port, one asynchronous read port, no reset.
// Zero read latency; no flow control of its own (the owner gates writes).
module pack_fifo_mem
    import pack_fifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pack_fifo_flush_p.sv
// Packing FIFO: IN_W beats -> PACK-lane rows, show-ahead read (row visible the cycle after commit),
// writes stall only when the row-completing beat meets a full buffer or while padding. PACK_FIFO_ERR_EN adds err_o.
module pack_fifo_flush_p
    import pack_fifo_pkg::*;
#(
    parameter int              IN_W  = 4,
    parameter int              PACK  = 8,
    parameter int              DEPTH = 4,
    parameter logic [IN_W-1:0] PAD   = 4'hC,
    localparam int             OUT_W = IN_W * PACK,
    localparam int             CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid_i,
    input  logic [IN_W-1:0]  wr_data_i,
    output logic             wr_ready_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [OUT_W-1:0] rd_data_o,
    output logic             rd_last_o,
    input  logic             flush_i,
    output logic             flush_done_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o,
    output logic             err_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              LW       = lane_w(PACK);
    localparam int              ACC_W    = IN_W * (PACK - 1);
    localparam logic [LW-1:0]   LAST     = LW'(PACK - 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);

    state_e            state;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     lane_ptr;
    logic [ACC_W-1:0]  acc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     drain_cnt;

    logic              full;
    logic              wr_fire;
    logic              rd_fire;
    logic              commit_wr;
    logic              commit_pad;
    logic              commit;
    logic [OUT_W-1:0]  acc_full;
    logic [OUT_W-1:0]  pad_row;
    logic [OUT_W-1:0]  row;
    logic [OUT_W-1:0]  head;

    assign full       = (count == DEPTH_C);
    assign wr_ready_o = (state != ST_PAD) && !((lane_ptr == LAST) && full);
    assign rd_valid_o = (count != '0);
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign rd_fire    = rd_valid_o && rd_ready_i;

    // A beat on the last lane completing a row coincident with the flush leaves lane_ptr at 0,
    // so PAD has nothing left to commit and must not emit an all-pad row.
    assign commit_wr  = wr_fire && (lane_ptr == LAST);
    assign commit_pad = (state == ST_PAD) && !full && (lane_ptr != '0);
    assign commit     = commit_wr || commit_pad;

    assign acc_full = {PAD, acc};

    always_comb begin
        pad_row = '0;
        for (int i = 0; i < PACK; i++) begin
            pad_row[i*IN_W +: IN_W] = (LW'(i) < lane_ptr) ? acc_full[i*IN_W +: IN_W] : PAD;
        end
    end

    assign row = commit_wr ? {wr_data_i, acc} : pad_row;

    pack_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (OUT_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (commit),
        .waddr (wr_ptr),
        .wdata (row),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lane_ptr <= '0;
            acc      <= '0;
            count    <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(commit) - CW'(rd_fire);

            if (commit) begin
                lane_ptr <= '0;
            end else if (wr_fire) begin
                lane_ptr <= lane_ptr + LW'(1);
            end
            for (int i = 0; i < PACK - 1; i++) begin
                if (wr_fire && (lane_ptr == LW'(i))) begin
                    acc[i*IN_W +: IN_W] <= wr_data_i;
                end
            end
        end
    end

    // drain_cnt tracks only rows that existed (or were partial) when the flush was taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_i) begin
                        drain_cnt <= count + CW'(lane_ptr != '0) - CW'(rd_fire);
                        state     <= (lane_ptr != '0) ? ST_PAD : ST_DRAIN;
                    end
                end
                ST_PAD: begin
                    drain_cnt <= drain_cnt - CW'(rd_fire);
                    if (!full || (lane_ptr == '0)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - CW'(rd_fire);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign flush_done_o = (state == ST_DRAIN) && (drain_cnt == '0);
    assign rd_last_o    = (state != ST_IDLE) && (drain_cnt == CW'(1)) && rd_valid_o;
    assign rd_data_o    = rd_valid_o ? head : '0;
    assign empty_o      = (count == '0) && (lane_ptr == '0);
    assign full_o       = full;
    assign count_o      = count;

`ifdef PACK_FIFO_ERR_EN
    logic err;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((wr_valid_i && !wr_ready_o) || (rd_ready_i && !rd_valid_o)) begin
            err <= 1'b1;
        end
    end

    assign err_o = err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pack_fifo_flush_p.sv
// Directed bench for pack_fifo_flush_p (IN_W=4, PACK=8, DEPTH=4, PAD=4'hC).
module tb_pack_fifo_flush_p;

`ifdef PACK_FIFO_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid_i;
    logic [3:0]  wr_data_i;
    logic        wr_ready_o;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [31:0] rd_data_o;
    logic        rd_last_o;
    logic        flush_i;
    logic        flush_done_o;
    logic        empty_o;
    logic        full_o;
    logic [2:0]  count_o;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pack_fifo_flush_p #(
        .IN_W  (4),
        .PACK  (8),
        .DEPTH (4),
        .PAD   (4'hC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid_i   (wr_valid_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_data_o    (rd_data_o),
        .rd_last_o    (rd_last_o),
        .flush_i      (flush_i),
        .flush_done_o (flush_done_o),
        .empty_o      (empty_o),
        .full_o       (full_o),
        .count_o      (count_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks run in that same settled window.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input logic [3:0] d);
        wr_valid_i = 1'b1;
        wr_data_i  = d;
        tick();
        wr_valid_i = 1'b0;
    endtask

    task automatic read_row(input string tag, input logic [31:0] exp_data, input logic exp_last);
        chk({tag, "_data"}, rd_data_o, exp_data);
        chk({tag, "_last"}, rd_last_o, exp_last);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr_ready"}, wr_ready_o, 1'b1);
        chk({tag, "_rd_valid"}, rd_valid_o, 1'b0);
        chk({tag, "_rd_data"}, rd_data_o, 32'h0);
        chk({tag, "_rd_last"}, rd_last_o, 1'b0);
        chk({tag, "_done"}, flush_done_o, 1'b0);
        chk({tag, "_empty"}, empty_o, 1'b1);
        chk({tag, "_full"}, full_o, 1'b0);
        chk({tag, "_count"}, count_o, 3'd0);
        chk({tag, "_err"}, err_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        wr_valid_i = 1'b0;
        wr_data_i  = 4'h0;
        rd_ready_i = 1'b0;
        flush_i    = 1'b0;
        tick();
        tick();
        check_reset("rst");
        reset = 1'b0;

        // 1: one full row, show-ahead
        for (int k = 1; k <= 8; k++) write_beat(4'(k));
        chk("t1_valid", rd_valid_o, 1'b1);
        chk("t1_count", count_o, 3'd1);
        chk("t1_last_idle", rd_last_o, 1'b0);
        read_row("t1", 32'h87654321, 1'b0);
        chk("t1_empty", empty_o, 1'b1);

        // 2: partial row padded on flush
        write_beat(4'hA);
        write_beat(4'hB);
        write_beat(4'hC);
        chk("t2_partial_empty", empty_o, 1'b0);
        do_flush();
        chk("t2_pad_wr_ready", wr_ready_o, 1'b0);
        tick();
        chk("t2_count", count_o, 3'd1);
        chk("t2_done_early", flush_done_o, 1'b0);
        read_row("t2", 32'hCCCCCCBA, 1'b1);
        chk("t2_done", flush_done_o, 1'b1);
        tick();
        chk("t2_done_pulse", flush_done_o, 1'b0);

        // 3: full buffer + 7 lanes, flush stalls in PAD until one read frees a slot
        for (int k = 0; k < 39; k++) write_beat(4'(k % 16));
        chk("t3_full", full_o, 1'b1);
        chk("t3_count", count_o, 3'd4);
        chk("t3_wr_ready", wr_ready_o, 1'b0);
        do_flush();
        tick();
        chk("t3_pad_hold_count", count_o, 3'd4);
        chk("t3_pad_wr_ready", wr_ready_o, 1'b0);
        read_row("t3_r1", 32'h76543210, 1'b0);
        chk("t3_after_read", count_o, 3'd3);
        tick();
        chk("t3_pad_commit", count_o, 3'd4);
        read_row("t3_r2", 32'hFEDCBA98, 1'b0);
        read_row("t3_r3", 32'h76543210, 1'b0);
        read_row("t3_r4", 32'hFEDCBA98, 1'b0);
        chk("t3_done_early", flush_done_o, 1'b0);
        read_row("t3_r5", 32'hC6543210, 1'b1);
        chk("t3_done", flush_done_o, 1'b1);
        tick();
        chk("t3_done_pulse", flush_done_o, 1'b0);

        // 4: flush of an empty FIFO
        chk("t4_empty", empty_o, 1'b1);
        do_flush();
        chk("t4_done", flush_done_o, 1'b1);
        chk("t4_valid", rd_valid_o, 1'b0);
        tick();
        chk("t4_done_pulse", flush_done_o, 1'b0);

        // 5: rows written during DRAIN are not part of the flush
        for (int k = 0; k < 16; k++) write_beat(4'(k));
        do_flush();
        for (int k = 1; k <= 8; k++) write_beat(4'(k));
        chk("t5_count", count_o, 3'd3);
        read_row("t5_r1", 32'h76543210, 1'b0);
        read_row("t5_r2", 32'hFEDCBA98, 1'b1);
        chk("t5_done", flush_done_o, 1'b1);
        chk("t5_count_left", count_o, 3'd1);
        tick();
        chk("t5_done_pulse", flush_done_o, 1'b0);
        read_row("t5_r3", 32'h87654321, 1'b0);

        // 6: reset mid-DRAIN
        for (int k = 1; k <= 8; k++) write_beat(4'(k));
        do_flush();
        chk("t6_last_before_rst", rd_last_o, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset("t6_rst");
        tick();
        chk("t6_no_done", flush_done_o, 1'b0);

        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        chk("t6_err_rd_empty", err_o, EXP_ERR);
        chk("t6_valid", rd_valid_o, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
